// File: rtl/wisc_mem_pkg.sv
// Shared memory-responder types.
// Word width, default latency and the response bundle.
package wisc_mem_pkg;

  localparam int WORD_W      = 16;
  localparam int MEM_LATENCY = 4;
  localparam int MEM_TAG_W   = 2;

  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] tag;
    logic [WORD_W-1:0]    data;
  } mem_resp_t;

endpackage

// File: rtl/mem4c_responder_resp_pipe.sv
// Fixed-depth response shift register.
// Advances every cycle; no stall path.
module resp_pipe
  import wisc_mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  mem_resp_t          d,
  output mem_resp_t          q,
  output logic [LATENCY-1:0] valids
);

  mem_resp_t stg [LATENCY];

  // Shift one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < LATENCY; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign q = stg[LATENCY-1];

  // Collect per-stage valid bits for the busy flag.
  always_comb begin
    valids = '0;
    for (int i = 0; i < LATENCY; i++)
      valids[i] = stg[i].valid;
  end

endmodule

// File: rtl/mem4c_responder.sv
// Fixed-latency pipelined main-memory responder.
// Reads capture data at issue; writes land in one cycle.
module mem4c_responder
  import wisc_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 32768,
  parameter int LATENCY = MEM_LATENCY,
  parameter int TAG_W   = MEM_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic [TAG_W-1:0]  tag_out,
  output logic              busy,
  output logic [3:0]        outstanding
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0]  mem [DEPTH];
  logic [IDX_W-1:0]   word;
  logic [WORD_W-1:0]  rd_data;
  logic               issue;
  logic               unused_addr;
  mem_resp_t          s1;
  mem_resp_t          last;
  logic [LATENCY-1:0] valids;
  logic [3:0]         cnt;

  // Byte address to word index; high bits alias.
  assign word        = addr[IDX_W:1];
  assign unused_addr = ^addr;
  assign issue       = enable & ~wr;
  assign rd_data     = mem[word];

  // Storage has no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (enable && wr)
      mem[word] <= data_in;
  end

  // Build stage-1 entry; bubbles carry zero tag/data.
  always_comb begin
    s1 = '0;
    if (issue) begin
      s1.valid = 1'b1;
      s1.tag   = MEM_TAG_W'(tag_in);
      s1.data  = rd_data;
    end
  end

  resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (s1),
    .q      (last),
    .valids (valids)
  );

  // Track reads in flight: +1 on issue, -1 on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 4'd0;
    else
      cnt <= cnt + {3'd0, issue} - {3'd0, last.valid};
  end

  assign data_valid  = last.valid;
  assign data_out    = last.data;
  assign tag_out     = TAG_W'(last.tag);
  assign busy        = |valids;
  assign outstanding = cnt;

endmodule

// File: tb/tb_mem4c_responder.sv
// Bench for mem4c_responder.
// Queue-based response model plus directed literal checks.
module tb_mem4c_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [1:0]  tag_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [1:0]  tag_out;
  logic        busy;
  logic [3:0]  outstanding;
  logic [15:0] d16_out;
  logic        v16;
  logic [1:0]  t16;
  logic        b16;
  logic [3:0]  o16;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcount   = 0;
  int peak     = 0;
  bit chk_en   = 0;

  logic [15:0] last16_data;
  logic        last16_valid;

  typedef struct {
    int          due;
    logic [1:0]  tag;
    logic [15:0] data;
  } exp_t;

  exp_t        mq [$];
  logic [15:0] mm [int];

  mem4c_responder dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
    .addr(addr), .data_in(data_in), .tag_in(tag_in),
    .data_out(data_out), .data_valid(data_valid),
    .tag_out(tag_out), .busy(busy), .outstanding(outstanding)
  );

  mem4c_responder #(.DEPTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
    .addr(addr), .data_in(data_in), .tag_in(tag_in),
    .data_out(d16_out), .data_valid(v16),
    .tag_out(t16), .busy(b16), .outstanding(o16)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Model: a read issued at edge N is seen at edge N+LAT.
  always @(posedge clk) begin
    int w;
    cyc = cyc + 1;
    if (!rst_n) begin
      mq.delete();
    end else if (enable) begin
      w = int'(addr[15:1]);
      if (wr)
        mm[w] = data_in;
      else
        mq.push_back('{cyc + LAT, tag_in,
                       mm.exists(w) ? mm[w] : 16'h0});
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      if (!rst_n) mq.delete();
      while (mq.size() > 0 && mq[0].due <= cyc)
        void'(mq.pop_front());
      ev = (mq.size() > 0) && (mq[0].due == cyc + 1);
      check("valid", data_valid, ev);
      check("data", data_out, ev ? mq[0].data : 16'h0);
      check("tag", tag_out, ev ? mq[0].tag : 2'd0);
      check("outstanding", outstanding, mq.size());
      check("busy", busy, mq.size() != 0);
      if (data_valid) vcount++;
      if (int'(outstanding) > peak) peak = int'(outstanding);
    end
  end

  task automatic drive(input logic e, input logic w,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] t, output int edge_n);
    enable  = e;
    wr      = w;
    addr    = a;
    data_in = d;
    tag_in  = t;
    @(posedge clk);
    #1;
    edge_n = cyc;
    enable = 1'b0;
  endtask

  task automatic expect_resp(input string nm, input int issue_edge,
                             input logic [15:0] ed,
                             input logic [1:0] et,
                             output int seen);
    bit found = 0;
    int k = 0;
    seen = -1;
    while (!found && k < 16) begin
      @(negedge clk);
      if (data_valid) begin
        found        = 1;
        seen         = cyc + 1;
        last16_data  = d16_out;
        last16_valid = v16;
      end
      k++;
    end
    if (!found) begin
      check({nm, "_timeout"}, 0, 1);
    end else begin
      check({nm, "_lat"}, seen - issue_edge, 4);
      check({nm, "_data"}, data_out, ed);
      check({nm, "_tag"}, tag_out, et);
    end
  endtask

  initial begin
    int e0, e1, e2, e3, s0, s1, s2, s3, v0;
    enable  = 0;
    wr      = 0;
    addr    = 0;
    data_in = 0;
    tag_in  = 0;
    rst_n   = 1;
    #1 rst_n = 0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Idle after reset.
    v0 = vcount;
    repeat (10) @(posedge clk);
    #1;
    check("idle_pulses", vcount - v0, 0);
    check("idle_out", outstanding, 0);
    check("idle_data", data_out, 0);

    // Write then read: latency, data, tag.
    drive(1, 1, 16'h0010, 16'hBEEF, 0, e0);
    drive(1, 0, 16'h0010, 16'h0, 2'd2, e1);
    expect_resp("rdlat", e1, 16'hBEEF, 2'd2, s0);

    // Streaming four reads.
    drive(1, 1, 16'h0000, 16'h1111, 0, e0);
    drive(1, 1, 16'h0002, 16'h2222, 0, e0);
    drive(1, 1, 16'h0004, 16'h3333, 0, e0);
    drive(1, 1, 16'h0006, 16'h4444, 0, e0);
    repeat (6) @(posedge clk);
    #1 peak = 0;
    drive(1, 0, 16'h0000, 0, 2'd0, e0);
    drive(1, 0, 16'h0002, 0, 2'd1, e1);
    drive(1, 0, 16'h0004, 0, 2'd2, e2);
    drive(1, 0, 16'h0006, 0, 2'd3, e3);
    expect_resp("st0", e0, 16'h1111, 2'd0, s0);
    expect_resp("st1", e1, 16'h2222, 2'd1, s1);
    expect_resp("st2", e2, 16'h3333, 2'd2, s2);
    expect_resp("st3", e3, 16'h4444, 2'd3, s3);
    check("st_consec", s3 - s0, 3);
    check("st_peak", peak, 4);

    // Capture at issue.
    drive(1, 1, 16'h0020, 16'h00AA, 0, e0);
    drive(1, 0, 16'h0020, 0, 2'd1, e1);
    drive(1, 1, 16'h0020, 16'h0055, 0, e2);
    drive(1, 0, 16'h0020, 0, 2'd3, e3);
    expect_resp("cap_old", e1, 16'h00AA, 2'd1, s0);
    expect_resp("cap_new", e3, 16'h0055, 2'd3, s1);
    repeat (6) @(posedge clk);
    #1;

    // Reset with two reads in flight.
    drive(1, 0, 16'h0000, 0, 2'd1, e0);
    drive(1, 0, 16'h0002, 0, 2'd2, e1);
    v0 = vcount;
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_pulses", vcount - v0, 0);
    check("rst_out", outstanding, 0);
    drive(1, 0, 16'h0010, 0, 2'd1, e0);
    expect_resp("rst_keep", e0, 16'hBEEF, 2'd1, s0);

    // Odd address and aliasing.
    drive(1, 1, 16'h0011, 16'h1234, 0, e0);
    drive(1, 0, 16'h0010, 0, 2'd0, e1);
    expect_resp("odd", e1, 16'h1234, 2'd0, s0);
    drive(1, 1, 16'h0030, 16'h0303, 0, e0);
    drive(1, 1, 16'h0010, 16'hCAFE, 0, e0);
    drive(1, 0, 16'h0030, 0, 2'd2, e1);
    expect_resp("noalias", e1, 16'h0303, 2'd2, s0);
    check("alias16_valid", last16_valid, 1);
    check("alias16_data", last16_data, 16'hCAFE);

    repeat (8) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem4c_responder.md
Name: mem4c_responder

Overview:
Multi-cycle main-memory responder that serves word read/write requests from the CPU-side cache fill/writeback logic. It replaces the single-cycle memory model with a fixed-latency, fully pipelined responder. It accepts one request per cycle. Each read returns its data exactly LATENCY cycles after issue, with a valid strobe and an echoed tag.

Parameters:
ADDR_W, 16, byte address width; word index = addr[ADDR_W-1:1]
DEPTH, 32768, number of 16-bit words stored (2^(ADDR_W-1))
LATENCY, 4, cycles from read issue to data_valid; legal range 1..8
TAG_W, 2, width of request tag echoed with read data

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  request strobe; request accepted every cycle it is high
wr  input  1  1 = write, 0 = read (sampled with enable)
addr  input  ADDR_W  byte address; addr[0] ignored
data_in  input  16  write data (used when enable & wr)
tag_in  input  TAG_W  request tag (reads only)
data_out  output  16  read data, valid only when data_valid=1
data_valid  output  1  one-cycle pulse per completed read
tag_out  output  TAG_W  tag of the read completing this cycle
busy  output  1  1 while any read is in flight (combinational OR of pipeline valids)
outstanding  output  4  count of reads in flight, 0..LATENCY

Behaviour:
- Reset (rst_n=0, async): all pipeline valid bits cleared; data_valid=0, data_out=0, tag_out=0, busy=0, outstanding=0. Storage array is NOT cleared; contents are preserved across reset.
- Reset mid-operation: in-flight reads are dropped, with no late data_valid after reset deasserts. A write sampled on the same edge that reset asserts is not guaranteed.
- Write: on the rising edge with enable & wr, mem[addr[ADDR_W-1:1]] <= data_in. The write takes effect in one cycle and produces no response. outstanding is unchanged.
- Read issue: on the rising edge with enable & ~wr, mem[word] is sampled in the issue cycle. Stage 1 of the pipeline loads {valid=1, tag_in, data}.
- Pipeline: LATENCY-stage shift register of {valid, tag, data}, advancing every cycle. It has no stall input: the responder never back-pressures.
- Output: data_valid/tag_out/data_out come from the final stage. A read issued at edge N gives data_valid=1 during cycle N+LATENCY.
  - data_out=0 and tag_out=0 whenever data_valid=0; no stale data is visible.
- Ordering: responses return in issue order. Back-to-back reads on consecutive cycles produce data_valid on consecutive cycles.
- Read-after-write: a read issued the cycle after a write to the same word returns the new data. A write issued while an earlier read of that word is in flight does not alter the read's data; the value is captured at issue.
- Same cycle: a single request per cycle, and wr selects its type. enable=0 inserts a bubble (valid=0) into stage 1.
- outstanding: +1 on read issue, -1 on data_valid, unchanged when both occur in the same cycle. It saturates at LATENCY by construction, and busy = (outstanding != 0).
- Wrap-around: the word index is truncated to log2(DEPTH) bits. Addresses beyond DEPTH alias modulo DEPTH.

Decomposition:
- Shared package (wisc_mem_pkg):
  - WORD_W=16
  - MEM_LATENCY=4
  - MEM_TAG_W=2
  - typedef mem_resp_t {valid, tag, data}
- One sub-module, resp_pipe: a parameterised LATENCY-deep shift register of mem_resp_t with async active-low clear.
- The top level holds the storage array, the write port, the read sampling and the outstanding counter.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then enable=0 for 10 cycles -> data_valid never 1, busy=0, outstanding=0, data_out=0.
- Write/read latency: write 0xBEEF @0x0010 at edge 0, read 0x0010 tag 2 at edge 1 -> data_valid=1 only in cycle 5, data_out=0xBEEF, tag_out=2.
- Streaming: reads of 0x0000,0x0002,0x0004,0x0006 (preloaded 0x1111..0x4444, tags 0..3) on 4 consecutive edges -> data_valid high 4 consecutive cycles starting 4 after first issue, data in order, outstanding peaks at 4.
- Capture-at-issue: read 0x0020 (holds 0x00AA), next cycle write 0x0055 to 0x0020 -> read returns 0x00AA; a subsequent read returns 0x0055.
- Reset mid-flight: issue 2 reads, assert rst_n low 1 cycle after the second -> no data_valid ever, outstanding=0. A read of a word written before reset returns its pre-reset value.
- Aliasing/odd address: write 0x1234 to addr 0x0011, read 0x0010 -> 0x1234. With DEPTH=16 override, read 0x0030 returns the word written at 0x0010.
